rtype_decode_stage: RTL and testbench

RTYPE_DECODE_STAGE -- requirements
Module: rtype_decode_stage

---
 rtl/rtype_decode_stage.sv | 184 ++++++++++++++++++
 tb/tb_rtype_decode_stage.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtype_decode_stage.sv
// rtype_decode_stage: R-type (SPECIAL opcode) decode pipeline stage.
// Accepts one instruction per valid/ready handshake and registers the decoded
// control word with a copy of the instruction. A busy counter tracks the
// multiply/divide unit and stalls HI/LO-class instructions while it runs.
// Optional feature macro: RTYPE_DECODE_HILO_EN enables HI/LO decode, the
// busy counter and the interlock. Without it HI/LO functs decode as reserved.

package signals;
    typedef enum logic [1:0] {ALU_SRCA_RS, ALU_SRCA_SHAMT, ALU_SRCA_NCARE} alu_srca_t;
    typedef enum logic       {ALU_SRCB_RT, ALU_SRCB_NCARE} alu_srcb_t;
    typedef enum logic       {DEST_REG_RD, DEST_REG_NCARE} dest_reg_t;
    typedef enum logic [1:0] {PC_SRC_NEXT, PC_SRC_REG, PC_SRC_EXECPTION, PC_SRC_NCARE} pc_src_t;
    typedef enum logic [1:0] {EXC_CHK_NONE, EXC_CHK_SYSCALL, EXC_CHK_BREAK, EXC_CHK_RESERVERD} exc_chk_t;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUBU, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_NCARE
    } alu_funct_t;

    typedef struct packed {
        alu_srca_t  alu_srcA;
        alu_srcb_t  alu_srcB;
        dest_reg_t  dest_reg;
        pc_src_t    pc_src;
        exc_chk_t   exc_chk;
        alu_funct_t alu_funct;
        logic       write_reg;
    } control_t;
endpackage

module rtype_decode_stage #(
    parameter int unsigned MUL_LATENCY = 4,
    parameter int unsigned DIV_LATENCY = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instruction,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output signals::control_t ctl,
    output logic [31:0]       out_instruction,
    output logic              hilo_busy
);
    import signals::*;

`ifdef RTYPE_DECODE_HILO_EN
    localparam logic HILO_EN = 1'b1;
`else
    localparam logic HILO_EN = 1'b0;
`endif

    localparam logic [7:0] MUL_LOAD = 8'(MUL_LATENCY);
    localparam logic [7:0] DIV_LOAD = 8'(DIV_LATENCY);

    localparam control_t CTL_DEFAULT = '{
        alu_srcA: ALU_SRCA_RS, alu_srcB: ALU_SRCB_RT, dest_reg: DEST_REG_RD,
        pc_src: PC_SRC_NEXT, exc_chk: EXC_CHK_NONE, alu_funct: ALU_NCARE,
        write_reg: 1'b1
    };
    localparam control_t CTL_RESERVED = '{
        alu_srcA: ALU_SRCA_NCARE, alu_srcB: ALU_SRCB_NCARE, dest_reg: DEST_REG_NCARE,
        pc_src: PC_SRC_EXECPTION, exc_chk: EXC_CHK_RESERVERD, alu_funct: ALU_NCARE,
        write_reg: 1'b0
    };
    localparam control_t CTL_RESET = '{
        alu_srcA: ALU_SRCA_NCARE, alu_srcB: ALU_SRCB_NCARE, dest_reg: DEST_REG_NCARE,
        pc_src: PC_SRC_NCARE, exc_chk: EXC_CHK_NONE, alu_funct: ALU_NCARE,
        write_reg: 1'b0
    };

    logic [5:0] funct;
    logic [5:0] opcode;
    logic [7:0] busy_cnt;
    logic       hilo_funct;
    logic       is_mul;
    logic       is_div;
    logic       interlock;
    logic       take;
    control_t   dec;

    assign funct  = instruction[5:0];
    assign opcode = instruction[31:26];

    // HI/LO-class funct detection (funct only; used for the interlock)
    always_comb begin
        hilo_funct = 1'b0;
        is_mul     = 1'b0;
        is_div     = 1'b0;
        case (funct)
            6'h10, 6'h11, 6'h12, 6'h13: hilo_funct = 1'b1;
            6'h18, 6'h19: begin hilo_funct = 1'b1; is_mul = (opcode == 6'h00); end
            6'h1A, 6'h1B: begin hilo_funct = 1'b1; is_div = (opcode == 6'h00); end
            default: hilo_funct = 1'b0;
        endcase
    end

    // Handshake: a transfer happens on a rising edge when in_valid && in_ready
    // && !flush. in_ready is combinational: the output slot is free or being
    // drained this cycle, and no HI/LO instruction is blocked by a busy unit.
    // out_valid holds ctl/out_instruction stable until out_ready is seen.
    assign interlock = HILO_EN && (busy_cnt != 8'd0) && hilo_funct;
    assign in_ready  = (!out_valid || out_ready) && !interlock;
    assign take      = in_valid && in_ready && !flush;
    assign hilo_busy = HILO_EN && (busy_cnt != 8'd0);

    // Decode the candidate instruction into a control word
    always_comb begin
        dec = CTL_DEFAULT;
        if (opcode != 6'h00) begin
            dec = CTL_RESERVED;
        end else begin
            case (funct)
                6'h20: dec.alu_funct = ALU_ADD;
                6'h21: dec.alu_funct = ALU_ADDU;
                6'h22: dec.alu_funct = ALU_SUB;
                6'h23: dec.alu_funct = ALU_SUBU;
                6'h24: dec.alu_funct = ALU_AND;
                6'h25: dec.alu_funct = ALU_OR;
                6'h26: dec.alu_funct = ALU_XOR;
                6'h27: dec.alu_funct = ALU_NOR;
                6'h2A: dec.alu_funct = ALU_SLT;
                6'h2B: dec.alu_funct = ALU_SLTU;
                6'h00: begin dec.alu_srcA = ALU_SRCA_SHAMT; dec.alu_funct = ALU_SLL; end
                6'h02: begin dec.alu_srcA = ALU_SRCA_SHAMT; dec.alu_funct = ALU_SRL; end
                6'h03: begin dec.alu_srcA = ALU_SRCA_SHAMT; dec.alu_funct = ALU_SRA; end
                6'h04: dec.alu_funct = ALU_SLL;
                6'h06: dec.alu_funct = ALU_SRL;
                6'h07: dec.alu_funct = ALU_SRA;
                6'h08: begin dec.pc_src = PC_SRC_REG; dec.write_reg = 1'b0; end
                6'h09: dec.pc_src = PC_SRC_REG;
                6'h0C: begin
                    dec.pc_src    = PC_SRC_EXECPTION;
                    dec.exc_chk   = EXC_CHK_SYSCALL;
                    dec.write_reg = 1'b0;
                end
                6'h0D: begin
                    dec.pc_src    = PC_SRC_EXECPTION;
                    dec.exc_chk   = EXC_CHK_BREAK;
                    dec.write_reg = 1'b0;
                end
                // MFHI/MFLO write a GPR; decode does not depend on the interlock
                6'h10, 6'h12: if (!HILO_EN) dec = CTL_RESERVED;
                6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: begin
                    if (HILO_EN) dec.write_reg = 1'b0;
                    else         dec = CTL_RESERVED;
                end
                default: dec = CTL_RESERVED;
            endcase
        end
    end

    // Output register: flush beats transfer, transfer beats drain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid       <= 1'b0;
            ctl             <= CTL_RESET;
            out_instruction <= 32'd0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (take) begin
            out_valid       <= 1'b1;
            ctl             <= dec;
            out_instruction <= instruction;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Busy counter: reload on issued mul/div, else count down to zero; flush
    // does not cancel an already-issued operation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_cnt <= 8'd0;
        end else if (HILO_EN && take && is_mul) begin
            busy_cnt <= MUL_LOAD;
        end else if (HILO_EN && take && is_div) begin
            busy_cnt <= DIV_LOAD;
        end else if (busy_cnt != 8'd0) begin
            busy_cnt <= busy_cnt - 8'd1;
        end
    end
endmodule

// File: tb/tb_rtype_decode_stage.sv
// tb_rtype_decode_stage: directed bench for rtype_decode_stage.
// HI/LO scenarios run when RTYPE_DECODE_HILO_EN is defined; otherwise the
// bench checks that HI/LO functs decode as reserved and never go busy.
module tb_rtype_decode_stage;
    import signals::*;

    logic        clk;
    logic        reset;
    logic [31:0] instruction;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    control_t    ctl;
    logic [31:0] out_instruction;
    logic        hilo_busy;

    int total;
    int bad;
    logic [31:0] exp_q[$];

    rtype_decode_stage #(.MUL_LATENCY(4), .DIV_LATENCY(32)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .ctl(ctl), .out_instruction(out_instruction),
        .hilo_busy(hilo_busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        instruction = 32'd0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // driver: present one instruction with out_ready=1, sample #1 after the edge
    task automatic issue(input logic [31:0] instr);
        @(negedge clk);
        instruction = instr; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        instruction = 32'h00851021;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (hilo_busy !== 1'b0) begin bad++; $display("FAIL reset_hilo_busy got=%b want=0", hilo_busy); end
        total++; if (out_instruction !== 32'd0) begin bad++; $display("FAIL reset_out_instr got=%h want=0", out_instruction); end
        total++; if (ctl.write_reg !== 1'b0) begin bad++; $display("FAIL reset_write_reg got=%b want=0", ctl.write_reg); end
        total++; if (ctl.exc_chk !== EXC_CHK_NONE) begin bad++; $display("FAIL reset_exc_chk got=%0d want=%0d", ctl.exc_chk, EXC_CHK_NONE); end
        total++; if (ctl.alu_srcA !== ALU_SRCA_NCARE) begin bad++; $display("FAIL reset_srcA got=%0d want=%0d", ctl.alu_srcA, ALU_SRCA_NCARE); end
        total++; if (ctl.pc_src !== PC_SRC_NCARE) begin bad++; $display("FAIL reset_pc_src got=%0d want=%0d", ctl.pc_src, PC_SRC_NCARE); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_addu();
        @(negedge clk);
        instruction = 32'h00851021; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL addu_in_ready got=%b want=1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL addu_out_valid got=%b want=1", out_valid); end
        total++; if (out_instruction !== 32'h00851021) begin bad++; $display("FAIL addu_out_instr got=%h want=00851021", out_instruction); end
        total++; if (ctl.write_reg !== 1'b1) begin bad++; $display("FAIL addu_write_reg got=%b want=1", ctl.write_reg); end
        total++; if (ctl.dest_reg !== DEST_REG_RD) begin bad++; $display("FAIL addu_dest got=%0d want=%0d", ctl.dest_reg, DEST_REG_RD); end
        total++; if (ctl.exc_chk !== EXC_CHK_NONE) begin bad++; $display("FAIL addu_exc got=%0d want=%0d", ctl.exc_chk, EXC_CHK_NONE); end
        total++; if (ctl.alu_funct !== ALU_ADDU) begin bad++; $display("FAIL addu_funct got=%0d want=%0d", ctl.alu_funct, ALU_ADDU); end
        total++; if (ctl.pc_src !== PC_SRC_NEXT) begin bad++; $display("FAIL addu_pc_src got=%0d want=%0d", ctl.pc_src, PC_SRC_NEXT); end
        // drain: no new transfer, out_ready=1 -> out_valid drops
        @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_out_valid got=%b want=0", out_valid); end
    endtask

    task automatic test_alu_shifts();
        logic [31:0] v_instr [10];
        alu_funct_t  v_fn    [10];
        alu_srca_t   v_a     [10];
        v_instr[0] = 32'h00851022; v_fn[0] = ALU_SUB;  v_a[0] = ALU_SRCA_RS;
        v_instr[1] = 32'h00851024; v_fn[1] = ALU_AND;  v_a[1] = ALU_SRCA_RS;
        v_instr[2] = 32'h00851025; v_fn[2] = ALU_OR;   v_a[2] = ALU_SRCA_RS;
        v_instr[3] = 32'h00851026; v_fn[3] = ALU_XOR;  v_a[3] = ALU_SRCA_RS;
        v_instr[4] = 32'h00851027; v_fn[4] = ALU_NOR;  v_a[4] = ALU_SRCA_RS;
        v_instr[5] = 32'h0085102A; v_fn[5] = ALU_SLT;  v_a[5] = ALU_SRCA_RS;
        v_instr[6] = 32'h0085102B; v_fn[6] = ALU_SLTU; v_a[6] = ALU_SRCA_RS;
        v_instr[7] = 32'h00041080; v_fn[7] = ALU_SLL;  v_a[7] = ALU_SRCA_SHAMT;
        v_instr[8] = 32'h00041083; v_fn[8] = ALU_SRA;  v_a[8] = ALU_SRCA_SHAMT;
        v_instr[9] = 32'h00851007; v_fn[9] = ALU_SRA;  v_a[9] = ALU_SRCA_RS;
        for (int i = 0; i < 10; i++) begin
            issue(v_instr[i]);
            total++; if (ctl.alu_funct !== v_fn[i]) begin bad++; $display("FAIL alu_funct[%0d] got=%0d want=%0d", i, ctl.alu_funct, v_fn[i]); end
            total++; if (ctl.alu_srcA !== v_a[i]) begin bad++; $display("FAIL alu_srcA[%0d] got=%0d want=%0d", i, ctl.alu_srcA, v_a[i]); end
            total++; if (ctl.alu_srcB !== ALU_SRCB_RT || ctl.write_reg !== 1'b1) begin bad++; $display("FAIL alu_srcB_wr[%0d] got=%0d/%b want=%0d/1", i, ctl.alu_srcB, ctl.write_reg, ALU_SRCB_RT); end
        end
    endtask

    task automatic test_jumps();
        issue(32'h03E00008);
        total++; if (ctl.pc_src !== PC_SRC_REG || ctl.write_reg !== 1'b0) begin bad++; $display("FAIL jr got=%0d/%b want=%0d/0", ctl.pc_src, ctl.write_reg, PC_SRC_REG); end
        issue(32'h0040F809);
        total++; if (ctl.pc_src !== PC_SRC_REG || ctl.write_reg !== 1'b1 || ctl.dest_reg !== DEST_REG_RD) begin bad++; $display("FAIL jalr got=%0d/%b/%0d want=%0d/1/%0d", ctl.pc_src, ctl.write_reg, ctl.dest_reg, PC_SRC_REG, DEST_REG_RD); end
    endtask

    task automatic test_exceptions();
        issue(32'h0000000C);
        total++; if (ctl.exc_chk !== EXC_CHK_SYSCALL || ctl.pc_src !== PC_SRC_EXECPTION || ctl.write_reg !== 1'b0) begin bad++; $display("FAIL syscall got=%0d/%0d/%b want=%0d/%0d/0", ctl.exc_chk, ctl.pc_src, ctl.write_reg, EXC_CHK_SYSCALL, PC_SRC_EXECPTION); end
        issue(32'h0000000D);
        total++; if (ctl.exc_chk !== EXC_CHK_BREAK || ctl.pc_src !== PC_SRC_EXECPTION || ctl.write_reg !== 1'b0) begin bad++; $display("FAIL break got=%0d/%0d/%b want=%0d/%0d/0", ctl.exc_chk, ctl.pc_src, ctl.write_reg, EXC_CHK_BREAK, PC_SRC_EXECPTION); end
        issue(32'h0000003F);
        total++; if (ctl.exc_chk !== EXC_CHK_RESERVERD || ctl.pc_src !== PC_SRC_EXECPTION || ctl.write_reg !== 1'b0) begin bad++; $display("FAIL funct3f got=%0d/%0d/%b want=%0d/%0d/0", ctl.exc_chk, ctl.pc_src, ctl.write_reg, EXC_CHK_RESERVERD, PC_SRC_EXECPTION); end
        total++; if (ctl.alu_srcA !== ALU_SRCA_NCARE || ctl.alu_srcB !== ALU_SRCB_NCARE || ctl.dest_reg !== DEST_REG_NCARE) begin bad++; $display("FAIL funct3f_srcs got=%0d/%0d/%0d want=ncare", ctl.alu_srcA, ctl.alu_srcB, ctl.dest_reg); end
        // non-zero opcode with an otherwise valid ADD funct
        issue(32'h08000020);
        total++; if (ctl.exc_chk !== EXC_CHK_RESERVERD || ctl.write_reg !== 1'b0) begin bad++; $display("FAIL opcode_nz got=%0d/%b want=%0d/0", ctl.exc_chk, ctl.write_reg, EXC_CHK_RESERVERD); end
    endtask

    task automatic test_backpressure();
        issue(32'h00851024);
        @(negedge clk);
        instruction = 32'h00851025; in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready[%0d] got=%b want=0", i, in_ready); end
            @(posedge clk);
            #1;
            total++; if (out_instruction !== 32'h00851024 || ctl.alu_funct !== ALU_AND || out_valid !== 1'b1) begin bad++; $display("FAIL stall_hold[%0d] got=%h/%0d want=00851024/%0d", i, out_instruction, ctl.alu_funct, ALU_AND); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b want=1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++; if (out_instruction !== 32'h00851025 || ctl.alu_funct !== ALU_OR) begin bad++; $display("FAIL release_next got=%h/%0d want=00851025/%0d", out_instruction, ctl.alu_funct, ALU_OR); end
    endtask

    task automatic test_flush();
        issue(32'h00851021);
        @(negedge clk);
        instruction = 32'h00851022; in_valid = 1'b1; out_ready = 1'b0; flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
        total++; if (out_instruction !== 32'h00851021) begin bad++; $display("FAIL flush_no_load got=%h want=00851021", out_instruction); end
    endtask

    // streaming with a directed out_ready pattern, checked via expected queue
    task automatic test_back_to_back();
        logic [31:0] stream [8];
        logic        rdy_pat [10];
        logic        ov_m;
        logic        rdy_exp;
        logic [31:0] head;
        int idx;
        stream[0] = 32'h00221820; stream[1] = 32'h00221821; stream[2] = 32'h00221822;
        stream[3] = 32'h00221823; stream[4] = 32'h00221824; stream[5] = 32'h00221825;
        stream[6] = 32'h00221826; stream[7] = 32'h00221827;
        rdy_pat[0] = 1; rdy_pat[1] = 1; rdy_pat[2] = 0; rdy_pat[3] = 1; rdy_pat[4] = 0;
        rdy_pat[5] = 0; rdy_pat[6] = 1; rdy_pat[7] = 1; rdy_pat[8] = 1; rdy_pat[9] = 1;
        do_reset();
        exp_q.delete();
        ov_m = 1'b0;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            out_ready = rdy_pat[c];
            in_valid = 1'b1;
            instruction = stream[idx % 8];
            #1;
            rdy_exp = !ov_m || rdy_pat[c];
            total++; if (out_valid !== ov_m) begin bad++; $display("FAIL b2b_out_valid[%0d] got=%b want=%b", c, out_valid, ov_m); end
            total++; if (in_ready !== rdy_exp) begin bad++; $display("FAIL b2b_in_ready[%0d] got=%b want=%b", c, in_ready, rdy_exp); end
            if (ov_m && rdy_pat[c]) begin
                head = exp_q.pop_front();
                total++; if (out_instruction !== head) begin bad++; $display("FAIL b2b_data[%0d] got=%h want=%h", c, out_instruction, head); end
            end
            if (rdy_exp) begin
                exp_q.push_back(stream[idx % 8]);
                idx++;
                ov_m = 1'b1;
            end else if (rdy_pat[c]) begin
                ov_m = 1'b0;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

`ifdef RTYPE_DECODE_HILO_EN
    task automatic test_mult_interlock();
        do_reset();
        issue(32'h00850018);
        total++; if (hilo_busy !== 1'b1 || ctl.write_reg !== 1'b0) begin bad++; $display("FAIL mult_issue got=%b/%b want=1/0", hilo_busy, ctl.write_reg); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            instruction = 32'h00001012; in_valid = 1'b1; out_ready = 1'b1;
            #1;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mflo_stall[%0d] got=%b want=0", i, in_ready); end
        end
        @(negedge clk);
        #1;
        total++; if (in_ready !== 1'b1 || hilo_busy !== 1'b0) begin bad++; $display("FAIL mflo_release got=%b/%b want=1/0", in_ready, hilo_busy); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++; if (out_instruction !== 32'h00001012 || ctl.write_reg !== 1'b1 || ctl.dest_reg !== DEST_REG_RD) begin bad++; $display("FAIL mflo_out got=%h/%b want=00001012/1", out_instruction, ctl.write_reg); end
        issue(32'h00400011);
        total++; if (ctl.write_reg !== 1'b0 || ctl.exc_chk !== EXC_CHK_NONE) begin bad++; $display("FAIL mthi got=%b/%0d want=0/%0d", ctl.write_reg, ctl.exc_chk, EXC_CHK_NONE); end
    endtask

    task automatic test_div_flush();
        int k;
        do_reset();
        issue(32'h0085001A);
        @(negedge clk);
        instruction = 32'h00851021; in_valid = 1'b1; flush = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        total++; if (out_valid !== 1'b0 || hilo_busy !== 1'b1) begin bad++; $display("FAIL div_flush got=%b/%b want=0/1", out_valid, hilo_busy); end
        k = 1;
        while (k < 32) begin
            @(posedge clk);
            #1;
            k++;
            if (k < 32) begin
                total++; if (hilo_busy !== 1'b1) begin bad++; $display("FAIL div_busy[%0d] got=%b want=1", k, hilo_busy); end
            end else begin
                total++; if (hilo_busy !== 1'b0) begin bad++; $display("FAIL div_done got=%b want=0", hilo_busy); end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        instruction = 32'h00850018; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if (hilo_busy !== 1'b0 || out_valid !== 1'b0 || out_instruction !== 32'd0) begin bad++; $display("FAIL reset_mid got=%b/%b/%h want=0/0/0", hilo_busy, out_valid, out_instruction); end
        @(negedge clk);
        reset = 1'b0;
    endtask
`else
    task automatic test_no_hilo();
        do_reset();
        issue(32'h00850018);
        total++; if (ctl.exc_chk !== EXC_CHK_RESERVERD || ctl.pc_src !== PC_SRC_EXECPTION || ctl.write_reg !== 1'b0) begin bad++; $display("FAIL mult_reserved got=%0d/%0d/%b want=%0d/%0d/0", ctl.exc_chk, ctl.pc_src, ctl.write_reg, EXC_CHK_RESERVERD, PC_SRC_EXECPTION); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            instruction = 32'h00001012; in_valid = 1'b0; out_ready = 1'b1;
            #1;
            total++; if (hilo_busy !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL no_hilo_busy[%0d] got=%b/%b want=0/1", i, hilo_busy, in_ready); end
        end
        issue(32'h00001012);
        total++; if (ctl.exc_chk !== EXC_CHK_RESERVERD || ctl.write_reg !== 1'b0) begin bad++; $display("FAIL mflo_reserved got=%0d/%b want=%0d/0", ctl.exc_chk, ctl.write_reg, EXC_CHK_RESERVERD); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        instruction = 32'h00851021; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || out_instruction !== 32'd0) begin bad++; $display("FAIL reset_mid got=%b/%h want=0/0", out_valid, out_instruction); end
        @(negedge clk);
        reset = 1'b0;
    endtask
`endif

    // sequence and final report
    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_addu();
        test_alu_shifts();
        test_jumps();
        test_exceptions();
        test_backpressure();
        test_flush();
        test_back_to_back();
`ifdef RTYPE_DECODE_HILO_EN
        test_mult_interlock();
        test_div_flush();
`else
        test_no_hilo();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
